// File: rtl/dmem_bridge.sv
// M-stage data-memory bridge: turns the core's one-cycle enable/write-enable
// request into a valid/ready bus access, with misalign detection and a bus timeout.
module dmem_bridge #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_en,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic [31:0] mem_rdata_M,
  output logic        stall_mem,
  output logic        bus_valid,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata,
  output logic        err_misalign,
  output logic        err_timeout
);

  localparam int DATA_W = 32;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [DATA_W-3:0] addr_p0;
  logic [DATA_W-1:0] wdata_p0;
  logic              we_p0;
  logic [TO_W-1:0]   cnt_p0;
  logic [DATA_W-1:0] rdata_p1;
  logic              err_to_p1;
  logic              err_mis_p1;

  logic misalign;
  logic to_hit;

  assign misalign = (req_addr[1:0] != 2'b00);
  // The current non-ready WAIT cycle is the TIMEOUT-th one.
  assign to_hit   = (cnt_p0 == TO_LAST);

  always_comb begin
    state_nxt = state;
    bus_valid = 1'b0;
    stall_mem = 1'b0;
    unique case (state)
      IDLE: begin
        stall_mem = req_en;
        if (req_en) begin
          state_nxt = misalign ? DONE : WAIT;
        end
      end
      WAIT: begin
        bus_valid = 1'b1;
        stall_mem = 1'b1;
        if (bus_ready || to_hit) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Stage p0: request capture; stage p1: completion result back to the core.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_p0    <= '0;
      wdata_p0   <= '0;
      we_p0      <= 1'b0;
      cnt_p0     <= '0;
      rdata_p1   <= '0;
      err_to_p1  <= 1'b0;
      err_mis_p1 <= 1'b0;
    end else begin
      state      <= state_nxt;
      err_mis_p1 <= (state == IDLE) && req_en && misalign;
      unique case (state)
        IDLE: begin
          if (req_en && !misalign) begin
            addr_p0  <= req_addr[DATA_W-1:2];
            wdata_p0 <= req_wdata;
            we_p0    <= req_we;
            cnt_p0   <= '0;
          end else if (req_en && !req_we) begin
            rdata_p1 <= '0;
          end
        end
        WAIT: begin
          if (bus_ready) begin
            if (!we_p0) begin
              rdata_p1 <= bus_rdata;
            end
          end else begin
            cnt_p0 <= cnt_p0 + TO_W'(1);
            if (to_hit) begin
              err_to_p1 <= 1'b1;
              if (!we_p0) begin
                rdata_p1 <= '0;
              end
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus_we       = we_p0;
  assign bus_addr     = {addr_p0, 2'b00};
  assign bus_wdata    = wdata_p0;
  assign mem_rdata_M  = rdata_p1;
  assign err_timeout  = err_to_p1;
  assign err_misalign = err_mis_p1;

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: transaction-level expectations checked
// every cycle, directed test-plan cases with literal values, then random traffic.
module tb_dmem_bridge;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_en = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        bus_ready = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic [31:0] mem_rdata_M;
  logic        stall_mem;
  logic        bus_valid;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        err_misalign;
  logic        err_timeout;

  dmem_bridge #(.TIMEOUT(TMO), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .req_en(req_en), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .mem_rdata_M(mem_rdata_M),
    .stall_mem(stall_mem), .bus_valid(bus_valid), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ready(bus_ready),
    .bus_rdata(bus_rdata), .err_misalign(err_misalign), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int dut_stalls = 0;
  int dut_valids = 0;

  bit          chk_on = 1'b0;
  bit          chk_bus = 1'b0;
  logic        e_stall = 1'b0, e_valid = 1'b0, e_we = 1'b0, e_mis = 1'b0, e_to = 1'b0;
  logic [31:0] e_addr = '0, e_wdata = '0, e_rdata = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (stall_mem === 1'b1) dut_stalls++;
    if (bus_valid === 1'b1) dut_valids++;
    if (chk_on) begin
      check("stall_mem", 32'(stall_mem), 32'(e_stall));
      check("bus_valid", 32'(bus_valid), 32'(e_valid));
      check("err_misalign", 32'(err_misalign), 32'(e_mis));
      check("err_timeout", 32'(err_timeout), 32'(e_to));
      check("mem_rdata_M", mem_rdata_M, e_rdata);
      if (chk_bus) begin
        check("bus_we", 32'(bus_we), 32'(e_we));
        check("bus_addr", bus_addr, e_addr);
        check("bus_wdata", bus_wdata, e_wdata);
      end
    end
  end

  task automatic quiet_exp();
    e_stall = 1'b0; e_valid = 1'b0; e_mis = 1'b0; chk_bus = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      req_en = 1'b0;
      req_addr = $urandom;
      bus_ready = 1'($urandom);
      bus_rdata = $urandom;
      quiet_exp();
    end
  endtask

  // One core access. d = non-ready WAIT cycles before the slave answers;
  // rdv = data returned on the answering cycle; done_req drives req_en in DONE.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input int d, input logic [31:0] rdv, input logic done_req);
    bit          to;
    int          n;
    logic [31:0] cap;
    cap = '0;
    @(posedge clk); #1;
    dut_stalls = 0;
    dut_valids = 0;
    req_en = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    bus_ready = 1'($urandom); bus_rdata = $urandom;
    e_stall = 1'b1; e_valid = 1'b0; e_mis = 1'b0; chk_bus = 1'b0;
    if (addr[1:0] != 2'b00) begin
      @(posedge clk); #1;
      req_en = done_req; req_addr = $urandom; req_we = 1'($urandom);
      bus_ready = 1'($urandom); bus_rdata = $urandom;
      quiet_exp();
      e_mis = 1'b1;
      if (!we) e_rdata = '0;
      return;
    end
    to = (d >= TMO);
    n  = to ? TMO : d + 1;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      bus_ready = (k == d + 1);
      bus_rdata = bus_ready ? rdv : $urandom;
      if (bus_ready) cap = rdv;
      e_stall = 1'b1; e_valid = 1'b1; e_mis = 1'b0; chk_bus = 1'b1;
      e_we = we; e_addr = {addr[31:2], 2'b00}; e_wdata = wdata;
    end
    @(posedge clk); #1;
    req_en = done_req; req_addr = $urandom; req_we = 1'($urandom);
    bus_ready = 1'($urandom); bus_rdata = $urandom;
    quiet_exp();
    if (!we) e_rdata = to ? 32'h0 : cap;
    if (to) e_to = 1'b1;
  endtask

  initial begin
    logic        we;
    logic [31:0] addr;

    repeat (3) @(posedge clk);
    #1;
    chk_on = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    check("reset bus_valid", 32'(bus_valid), 32'h0);
    check("reset stall_mem", 32'(stall_mem), 32'h0);
    check("reset mem_rdata_M", mem_rdata_M, 32'h0);
    check("reset err_timeout", 32'(err_timeout), 32'h0);
    idle(2);

    // Zero-wait read
    txn(1'b0, 32'h0000_0010, 32'h0, 0, 32'h1234_5678, 1'b0);
    @(negedge clk);
    check("read0 mem_rdata_M", mem_rdata_M, 32'h1234_5678);
    check("read0 stall cycles", 32'(dut_stalls), 32'd2);
    check("read0 valid cycles", 32'(dut_valids), 32'd1);
    idle(1);

    // Write with three non-ready cycles
    txn(1'b1, 32'h0000_0020, 32'hCAFE_F00D, 3, 32'hDEAD_BEEF, 1'b1);
    @(negedge clk);
    check("write3 mem_rdata_M", mem_rdata_M, 32'h1234_5678);
    check("write3 stall cycles", 32'(dut_stalls), 32'd5);
    check("write3 valid cycles", 32'(dut_valids), 32'd4);
    idle(1);

    // Misaligned read
    txn(1'b0, 32'h0000_0013, 32'h0, 0, 32'h5555_5555, 1'b0);
    @(negedge clk);
    check("misalign pulse", 32'(err_misalign), 32'h1);
    check("misalign mem_rdata_M", mem_rdata_M, 32'h0);
    check("misalign stall cycles", 32'(dut_stalls), 32'd1);
    check("misalign valid cycles", 32'(dut_valids), 32'd0);
    idle(1);

    // Ready on the last allowed WAIT cycle wins over the timeout
    txn(1'b0, 32'h0000_0040, 32'h0, TMO - 1, 32'hA5A5_0F0F, 1'b0);
    @(negedge clk);
    check("edge err_timeout", 32'(err_timeout), 32'h0);
    check("edge mem_rdata_M", mem_rdata_M, 32'hA5A5_0F0F);
    idle(1);

    // Dead slave
    txn(1'b0, 32'h0000_0044, 32'h0, 20, 32'h0, 1'b0);
    @(negedge clk);
    check("timeout err_timeout", 32'(err_timeout), 32'h1);
    check("timeout mem_rdata_M", mem_rdata_M, 32'h0);
    check("timeout valid cycles", 32'(dut_valids), 32'd4);
    check("timeout stall cycles", 32'(dut_stalls), 32'd5);
    idle(2);
    @(negedge clk);
    check("timeout sticky", 32'(err_timeout), 32'h1);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      we   = 1'($urandom);
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      else if (addr[1:0] == 2'b00) addr[1:0] = 2'b10;
      txn(we, addr, $urandom, int'($urandom_range(0, 6)), $urandom, 1'($urandom));
      idle(int'($urandom_range(0, 2)));
    end

    // Reset in the second WAIT cycle of a read
    txn(1'b0, 32'h0000_0100, 32'h0, 20, 32'h0, 1'b0);
    idle(1);
    @(posedge clk); #1;
    req_en = 1'b1; req_we = 1'b0; req_addr = 32'h0000_0080;
    bus_ready = 1'b0;
    e_stall = 1'b1; e_valid = 1'b0; e_mis = 1'b0; chk_bus = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk); #1;
      bus_ready = 1'b0;
      if (k == 2) rst = 1'b1;
      e_stall = 1'b1; e_valid = 1'b1; chk_bus = 1'b1;
      e_we = 1'b0; e_addr = 32'h0000_0080; e_wdata = req_wdata;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    req_en = 1'b0;
    quiet_exp();
    e_to = 1'b0;
    e_rdata = '0;
    @(negedge clk);
    check("rst bus_valid", 32'(bus_valid), 32'h0);
    check("rst stall_mem", 32'(stall_mem), 32'h0);
    check("rst err_timeout", 32'(err_timeout), 32'h0);
    check("rst mem_rdata_M", mem_rdata_M, 32'h0);
    idle(1);

    txn(1'b0, 32'h0000_0200, 32'h0, 1, 32'h0BAD_F00D, 1'b0);
    @(negedge clk);
    check("recover mem_rdata_M", mem_rdata_M, 32'h0BAD_F00D);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
